// File: rtl/ace_rle_loader.sv
// ace_rle_loader: ACE snapshot loader expanding ESC,count,data run records from ioctl into RAM writes
// Ports:
//   clk_sys, reset                system clock and synchronous active-high reset
//   ioctl_download/index/wr/dout  hps_io download stream (index 0 ignored)
//   raw_mode                      copy bytes verbatim, latched at download start
//   ioctl_wait                    stall request back to hps_io
//   loader_en, loader_reset       RAM port ownership and one-cycle core reset pulse
//   loader_wr/addr/data           RAM write strobe, address and data
//   done, overflow                sticky end-marker and address-overflow flags
module ace_rle_loader #(
   parameter int              ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] START_ADDR = 'h2000,
   parameter logic [7:0]      ESC        = 8'hED,
   parameter int              HOLD_CYC   = 3000000
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [7:0]        ioctl_dout,
   input  logic              raw_mode,
   output logic              ioctl_wait,
   output logic              loader_en,
   output logic              loader_reset,
   output logic              loader_wr,
   output logic [ADDR_W-1:0] loader_addr,
   output logic [7:0]        loader_data,
   output logic              done,
   output logic              overflow
);
   localparam int HW = $clog2(HOLD_CYC + 1);
   typedef enum logic [2:0] {IDLE, HOLD, LIT, CNT, DAT, RUN, END} state_t;
   state_t        state;
   logic [HW-1:0] hold;
   logic [7:0]    cnt;
   logic          raw;
   logic          dl_q;
   logic          start, stop, byte_ok, blocked;
   assign start   = ioctl_download && !dl_q && ioctl_index != 8'd0;
   assign stop    = !ioctl_download && dl_q;
   assign byte_ok = ioctl_wr && ioctl_index != 8'd0 && !ioctl_wait;
   // a pulse at the top address already in flight blocks any further write
   assign blocked = overflow || (loader_wr && loader_addr == '1);
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state        <= IDLE;
         hold         <= '0;
         cnt          <= 8'd0;
         raw          <= 1'b0;
         // track the live level so a download still active after reset is not seen as a new start
         dl_q         <= ioctl_download;
         ioctl_wait   <= 1'b0;
         loader_en    <= 1'b0;
         loader_reset <= 1'b0;
         loader_wr    <= 1'b0;
         loader_addr  <= START_ADDR;
         loader_data  <= 8'd0;
         done         <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         dl_q         <= ioctl_download;
         loader_reset <= start;
         loader_wr    <= 1'b0;
         if (loader_wr) loader_addr <= loader_addr + 1'b1;
         if (loader_wr && loader_addr == '1) overflow <= 1'b1;
         if (stop) begin
            state      <= IDLE;
            loader_en  <= 1'b0;
            ioctl_wait <= 1'b0;
         end else if (start) begin
            state       <= HOLD;
            hold        <= HW'(HOLD_CYC);
            cnt         <= 8'd0;
            raw         <= raw_mode;
            ioctl_wait  <= 1'b1;
            done        <= 1'b0;
            overflow    <= 1'b0;
            loader_addr <= START_ADDR;
         end else begin
            if (byte_ok && state != IDLE) loader_en <= 1'b1;
            case (state)
               HOLD: begin
                  if (hold == '0) begin
                     ioctl_wait <= 1'b0;
                     state      <= LIT;
                  end else hold <= hold - 1'b1;
               end
               LIT: begin
                  if (byte_ok) begin
                     if (raw || ioctl_dout != ESC) begin
                        loader_data <= ioctl_dout;
                        loader_wr   <= !blocked;
                     end else state <= CNT;
                  end
               end
               CNT: begin
                  if (byte_ok) begin
                     if (ioctl_dout == 8'd0) begin
                        state <= END;
                        done  <= 1'b1;
                     end else begin
                        cnt   <= ioctl_dout;
                        state <= DAT;
                     end
                  end
               end
               DAT: begin
                  if (byte_ok) begin
                     loader_data <= ioctl_dout;
                     ioctl_wait  <= 1'b1;
                     state       <= RUN;
                  end
               end
               RUN: begin
                  // one pulse every other cycle; the count drains even when writes are blocked
                  if (!loader_wr) begin
                     if (cnt != 8'd0) begin
                        loader_wr <= !blocked;
                        cnt       <= cnt - 1'b1;
                     end else begin
                        ioctl_wait <= 1'b0;
                        state      <= LIT;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ace_rle_loader.sv
// tb_ace_rle_loader: directed table and sequence checks of ace_rle_loader
module tb_ace_rle_loader;
   logic       clk_sys = 1'b0, reset = 1'b1, dl1 = 1'b0, dl2 = 1'b0, ioctl_wr = 1'b0, raw_mode = 1'b0;
   logic [7:0] ioctl_index = 8'd0, ioctl_dout = 8'd0;
   logic       w1, en1, lr1, wr1, done1, ov1, w2, en2, lr2, wr2, done2, ov2;
   logic [15:0] a1, a2;
   logic [7:0]  d1, d2;
   int n_cmp = 0, n_bad = 0, cyc = 0;

   ace_rle_loader #(.ADDR_W(16), .START_ADDR(16'h2000), .ESC(8'hED), .HOLD_CYC(4)) u1 (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl1), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .raw_mode(raw_mode), .ioctl_wait(w1),
      .loader_en(en1), .loader_reset(lr1), .loader_wr(wr1), .loader_addr(a1), .loader_data(d1),
      .done(done1), .overflow(ov1));

   ace_rle_loader #(.ADDR_W(16), .START_ADDR(16'hFFFE), .ESC(8'hED), .HOLD_CYC(4)) u2 (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl2), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .raw_mode(raw_mode), .ioctl_wait(w2),
      .loader_en(en2), .loader_reset(lr2), .loader_wr(wr2), .loader_addr(a2), .loader_data(d2),
      .done(done2), .overflow(ov2));

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct packed {logic [15:0] a; logic [7:0] d; int t; logic w;} wr_t;
   wr_t q1[$], q2[$];
   always @(negedge clk_sys) begin
      if (wr1) q1.push_back('{a: a1, d: d1, t: cyc, w: w1});
      if (wr2) q2.push_back('{a: a2, d: d2, t: cyc, w: w2});
   end

   typedef struct packed {
      logic            raw;
      logic            gap;
      logic            done;
      logic [3:0]      nb;
      logic [3:0]      nw;
      logic [0:5][7:0]  b;
      logic [0:5][15:0] a;
      logic [0:5][7:0]  d;
   } vec_t;
   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      while ((w1 | w2) && n < 2000) begin
         tick(1);
         n++;
      end
      chk("wait_release", {31'd0, w1 | w2}, 32'd0);
      ioctl_wr   = 1'b1;
      ioctl_dout = b;
      tick(1);
      ioctl_wr   = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int wc, rc, nq;
      vt[0] = '{raw: 1'b0, gap: 1'b0, done: 1'b0, nb: 4'd3, nw: 4'd3,
                b: {8'h01, 8'h02, 8'h03, 24'h0},
                a: {16'h2000, 16'h2001, 16'h2002, 48'h0},
                d: {8'h01, 8'h02, 8'h03, 24'h0}};
      vt[1] = '{raw: 1'b0, gap: 1'b1, done: 1'b0, nb: 4'd4, nw: 4'd5,
                b: {8'hED, 8'h04, 8'hAA, 8'h55, 16'h0},
                a: {16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h0},
                d: {8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h0}};
      vt[2] = '{raw: 1'b0, gap: 1'b0, done: 1'b1, nb: 4'd4, nw: 4'd0,
                b: {8'hED, 8'h00, 8'h11, 8'h22, 16'h0}, a: '0, d: '0};
      vt[3] = '{raw: 1'b1, gap: 1'b0, done: 1'b0, nb: 4'd3, nw: 4'd3,
                b: {8'hED, 8'h00, 8'h11, 24'h0},
                a: {16'h2000, 16'h2001, 16'h2002, 48'h0},
                d: {8'hED, 8'h00, 8'h11, 24'h0}};
      vt[4] = '{raw: 1'b0, gap: 1'b0, done: 1'b0, nb: 4'd5, nw: 4'd4,
                b: {8'h10, 8'hED, 8'h02, 8'hED, 8'h33, 8'h0},
                a: {16'h2000, 16'h2001, 16'h2002, 16'h2003, 32'h0},
                d: {8'h10, 8'hED, 8'hED, 8'h33, 16'h0}};
      vt[5] = '{raw: 1'b0, gap: 1'b0, done: 1'b0, nb: 4'd3, nw: 4'd1,
                b: {8'h44, 8'hED, 8'h03, 24'h0},
                a: {16'h2000, 80'h0},
                d: {8'h44, 40'h0}};

      tick(1);
      do_reset;
      chk("rst_addr", {16'd0, a1}, 32'h2000);
      chk("rst_wait", {31'd0, w1}, 32'd0);
      chk("rst_flags", {28'd0, en1, lr1, done1, ov1}, 32'd0);

      // T1: reset pulse and wait-high length
      q1.delete();
      ioctl_index = 8'd1;
      dl1 = 1'b1;
      wc = 0;
      rc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_sys);
         wc += int'(w1);
         rc += int'(lr1);
      end
      chk("t1_wait_cycles", wc, 32'd5);
      chk("t1_reset_cycles", rc, 32'd1);
      chk("t1_no_writes", q1.size(), 32'd0);
      dl1 = 1'b0;
      tick(2);

      // stream table
      for (int i = 0; i < 6; i++) begin
         q1.delete();
         ioctl_index = 8'd1;
         raw_mode = vt[i].raw;
         dl1 = 1'b1;
         tick(1);
         for (int j = 0; j < int'(vt[i].nb); j++) send(vt[i].b[j]);
         tick(12);
         chk($sformatf("v%0d_nwr", i), q1.size(), {28'd0, vt[i].nw});
         for (int j = 0; j < int'(vt[i].nw); j++)
            if (j < q1.size()) begin
               chk($sformatf("v%0d_addr%0d", i, j), {16'd0, q1[j].a}, {16'd0, vt[i].a[j]});
               chk($sformatf("v%0d_data%0d", i, j), {24'd0, q1[j].d}, {24'd0, vt[i].d[j]});
            end
         if (vt[i].gap)
            for (int j = 1; j < 4; j++)
               if (j < q1.size()) begin
                  chk($sformatf("v%0d_gap%0d", i, j), q1[j].t - q1[j-1].t, 32'd2);
                  chk($sformatf("v%0d_runwait%0d", i, j), {31'd0, q1[j].w}, 32'd1);
               end
         chk($sformatf("v%0d_done", i), {31'd0, done1}, {31'd0, vt[i].done});
         chk($sformatf("v%0d_en", i), {31'd0, en1}, 32'd1);
         dl1 = 1'b0;
         raw_mode = 1'b0;
         tick(2);
      end

      // T5: overflow at the top of the address space
      q1.delete();
      q2.delete();
      dl2 = 1'b1;
      tick(1);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      tick(6);
      chk("t5_nwr", q2.size(), 32'd2);
      if (q2.size() >= 2) begin
         chk("t5_a0", {16'd0, q2[0].a}, 32'hFFFE);
         chk("t5_d0", {24'd0, q2[0].d}, 32'h01);
         chk("t5_a1", {16'd0, q2[1].a}, 32'hFFFF);
         chk("t5_d1", {24'd0, q2[1].d}, 32'h02);
      end
      chk("t5_overflow", {31'd0, ov2}, 32'd1);
      chk("t5_other_idle", q1.size(), 32'd0);
      dl2 = 1'b0;
      tick(2);
      chk("t5_ovf_kept", {31'd0, ov2}, 32'd1);

      // T6: reset in the middle of a long run
      do_reset;
      q1.delete();
      dl1 = 1'b1;
      tick(1);
      send(8'hED);
      send(8'hFF);
      send(8'h77);
      tick(6);
      chk("t6_running", {31'd0, q1.size() > 0}, 32'd1);
      chk("t6_wait_before", {31'd0, w1}, 32'd1);
      reset = 1'b1;
      tick(1);
      chk("t6_wait", {31'd0, w1}, 32'd0);
      chk("t6_wr", {31'd0, wr1}, 32'd0);
      chk("t6_addr", {16'd0, a1}, 32'h2000);
      chk("t6_flags", {29'd0, en1, done1, ov1}, 32'd0);
      reset = 1'b0;
      nq = q1.size();
      tick(20);
      send(8'h12);
      tick(4);
      chk("t6_no_more_writes", q1.size(), nq);
      chk("t6_wait_after", {31'd0, w1}, 32'd0);
      chk("t6_en_after", {31'd0, en1}, 32'd0);
      dl1 = 1'b0;
      tick(2);

      // T7: download drop during a run
      q1.delete();
      dl1 = 1'b1;
      tick(1);
      send(8'hED);
      send(8'h05);
      send(8'h66);
      tick(3);
      chk("t7_en_before", {31'd0, en1}, 32'd1);
      chk("t7_wait_before", {31'd0, w1}, 32'd1);
      dl1 = 1'b0;
      tick(1);
      chk("t7_en", {31'd0, en1}, 32'd0);
      chk("t7_wait", {31'd0, w1}, 32'd0);
      nq = q1.size();
      tick(20);
      chk("t7_writes_stop", q1.size(), nq);

      // T8: index 0 download is ignored
      do_reset;
      q1.delete();
      ioctl_index = 8'd0;
      dl1 = 1'b1;
      rc = 0;
      wc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_sys);
         wc += int'(w1);
         rc += int'(lr1);
      end
      tick(1);
      send(8'h01);
      send(8'hED);
      tick(3);
      chk("t8_no_writes", q1.size(), 32'd0);
      chk("t8_no_wait", wc, 32'd0);
      chk("t8_no_reset", rc, 32'd0);
      chk("t8_en", {31'd0, en1}, 32'd0);
      chk("t8_addr", {16'd0, a1}, 32'h2000);
      dl1 = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
